// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage branch/jump resolution, mispredict redirect,
// multi-cycle front-end flush and predictor update record.
// Optional build macro BRU_STATS_EN adds saturating resolve/mispredict counters
// (ports stat_resolved, stat_mispred).
module branch_resolve_unit #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [2:0]  funct3,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    input  logic [31:0] pc,
    input  logic [31:0] pred_pc,
    input  logic [31:0] branch_target,
    input  logic [31:0] jal_target,
    input  logic [31:0] jalr_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        upd_valid,
    output logic [31:0] upd_pc,
    output logic        upd_taken,
    output logic        illegal_br
`ifdef BRU_STATS_EN
    ,
    output logic [31:0] stat_resolved,
    output logic [31:0] stat_mispred
`endif
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    logic              accept_c;
    logic              is_ctrl_c;
    logic              taken_c;
    logic              illegal_c;
    logic [XLEN-1:0]   target_c;
    logic [XLEN-1:0]   seq_pc_c;
    logic [XLEN-1:0]   actual_c;
    logic              mispredict_c;

    assign ex_ready = (state == IDLE);

    // Direction and target decode; jalr > jal > branch priority
    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        target_c  = branch_target;
        if (is_jalr) begin
            taken_c  = 1'b1;
            target_c = {jalr_target[XLEN-1:1], 1'b0};
        end else if (is_jal) begin
            taken_c  = 1'b1;
            target_c = jal_target;
        end else if (is_branch) begin
            case (funct3)
                3'b000:  taken_c = br_eq;
                3'b001:  taken_c = !br_eq;
                3'b100:  taken_c = br_lt;
                3'b101:  taken_c = !br_lt;
                3'b110:  taken_c = br_ltu;
                3'b111:  taken_c = !br_ltu;
                default: begin
                    taken_c   = 1'b0;
                    illegal_c = 1'b1;
                end
            endcase
        end
    end

    // Resolved next PC and mispredict detection (32-bit wrap on pc+4)
    always_comb begin
        accept_c     = ex_valid && ex_ready;
        is_ctrl_c    = is_branch || is_jal || is_jalr;
        seq_pc_c     = pc + XLEN'(4);
        actual_c     = taken_c ? target_c : seq_pc_c;
        mispredict_c = is_ctrl_c && (actual_c != pred_pc);
    end

    // Resolve FSM with registered pulses and flush hold counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            flush       <= 1'b0;
            upd_valid   <= 1'b0;
            upd_pc      <= '0;
            upd_taken   <= 1'b0;
            illegal_br  <= 1'b0;
        end else begin
            redirect   <= 1'b0;
            upd_valid  <= 1'b0;
            illegal_br <= 1'b0;
            case (state)
                IDLE: begin
                    flush <= 1'b0;
                    if (accept_c && is_ctrl_c) begin
                        upd_valid  <= 1'b1;
                        upd_pc     <= pc;
                        upd_taken  <= taken_c;
                        illegal_br <= illegal_c && !is_jal && !is_jalr;
                        if (mispredict_c) begin
                            redirect    <= 1'b1;
                            redirect_pc <= actual_c;
                            flush       <= 1'b1;
                            cnt         <= CNT_W'(FLUSH_CYCLES - 1);
                            state       <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (cnt == '0) begin
                        flush <= 1'b0;
                        state <= IDLE;
                    end else begin
                        flush <= 1'b1;
                        cnt   <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    flush <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BRU_STATS_EN
    // Saturating event counters driven by the registered pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved <= '0;
            stat_mispred  <= '0;
        end else begin
            if (upd_valid && (stat_resolved != '1)) begin
                stat_resolved <= stat_resolved + XLEN'(1);
            end
            if (redirect && (stat_mispred != '1)) begin
                stat_mispred <= stat_mispred + XLEN'(1);
            end
        end
    end
`endif

endmodule
